// File: rtl/io_irq_pkg.sv
// Shared defaults and ID encoding for the board I/O interrupt controller.
package io_irq_pkg;

  localparam int unsigned N_SW_DEF  = 8;
  localparam int unsigned N_BTN_DEF = 5;
  localparam int unsigned IRQ_ID_W  = 4;

  localparam logic [IRQ_ID_W-1:0] IRQ_ID_NONE = 4'hF;

endpackage

// File: rtl/io_edge_det.sv
// Multi-stage synchroniser with previous-value flop and rise/fall detection,
// gated off until the pipeline has loaded after reset.
module io_edge_det #(
  parameter int unsigned WIDTH       = 1,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             ACLK,
  input  logic             ARESETn,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  localparam int unsigned WARM  = SYNC_STAGES + 1;
  localparam int unsigned CNT_W = $clog2(WARM + 1);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] sync_out;
  logic [CNT_W-1:0] warm_cnt;
  logic             ready;

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign ready    = (warm_cnt == CNT_W'(WARM));

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev_q   <= '0;
      warm_cnt <= '0;
    end else begin
      sync_q[0] <= din;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= sync_out;
      if (!ready) warm_cnt <= warm_cnt + 1'b1;
    end
  end

  // Lines held high through reset look like a rise until prev_q has loaded.
  always_comb begin
    rise = '0;
    fall = '0;
    if (ready) begin
      rise = sync_out & ~prev_q;
      fall = ~sync_out & prev_q;
    end
  end

endmodule

// File: rtl/io_irq_ctrl.sv
// Switch/button interrupt controller: sticky per-source pending status,
// masked priority encode to a source ID, and a level or pulse PS interrupt.
module io_irq_ctrl
  import io_irq_pkg::*;
#(
  parameter int unsigned N_SW        = N_SW_DEF,
  parameter int unsigned N_BTN       = N_BTN_DEF,
  parameter int unsigned SYNC_STAGES = 2,
  parameter bit          IRQ_LEVEL   = 1'b1
) (
  input  logic                ACLK,
  input  logic                ARESETn,
  input  logic [N_SW-1:0]     switch,
  input  logic [N_BTN-1:0]    button,
  input  logic [N_SW-1:0]     int_switch_ena,
  input  logic [N_BTN-1:0]    int_button_ena,
  input  logic [N_SW-1:0]     int_switch_clr,
  input  logic [N_BTN-1:0]    int_button_clr,
  input  logic [N_BTN-1:0]    button_posedge,
  input  logic [N_BTN-1:0]    button_negedge,
  output logic [N_SW-1:0]     int_switch_sts,
  output logic [N_BTN-1:0]    int_button_sts,
  output logic                irq,
  output logic [IRQ_ID_W-1:0] irq_id
);

  localparam int unsigned N_SRC = N_SW + N_BTN;

  logic [N_SW-1:0]     sw_rise, sw_fall, sw_evt;
  logic [N_BTN-1:0]    btn_rise, btn_fall, btn_evt;
  logic [N_SRC-1:0]    sts_all, masked;
  logic [IRQ_ID_W-1:0] id_next;
  logic                irq_next;

  io_edge_det #(.WIDTH(N_SW), .SYNC_STAGES(SYNC_STAGES)) u_sw_det (
    .ACLK    (ACLK),
    .ARESETn (ARESETn),
    .din     (switch),
    .rise    (sw_rise),
    .fall    (sw_fall)
  );

  io_edge_det #(.WIDTH(N_BTN), .SYNC_STAGES(SYNC_STAGES)) u_btn_det (
    .ACLK    (ACLK),
    .ARESETn (ARESETn),
    .din     (button),
    .rise    (btn_rise),
    .fall    (btn_fall)
  );

  assign sw_evt  = sw_rise | sw_fall;
  assign btn_evt = (btn_rise & button_posedge) | (btn_fall & button_negedge);

  assign sts_all = {int_button_sts, int_switch_sts};
  assign masked  = {int_button_sts & int_button_ena, int_switch_sts & int_switch_ena};

  // Set term is OR-ed after the clear so a same-edge event is never lost.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      int_switch_sts <= '0;
      int_button_sts <= '0;
    end else begin
      int_switch_sts <= (int_switch_sts & ~int_switch_clr) | (sw_evt & int_switch_ena);
      int_button_sts <= (int_button_sts & ~int_button_clr) | (btn_evt & int_button_ena);
    end
  end

  always_comb begin
    id_next = IRQ_ID_NONE;
    for (int unsigned i = N_SRC; i > 0; i--) begin
      if (masked[i-1]) id_next = IRQ_ID_W'(i - 1);
    end
  end

  if (IRQ_LEVEL) begin : g_level
    assign irq_next = |masked;
  end else begin : g_pulse
    logic [N_SRC-1:0] sts_d;
    always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) sts_d <= '0;
      else          sts_d <= sts_all;
    end
    assign irq_next = |(sts_all & ~sts_d);
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      irq    <= 1'b0;
      irq_id <= IRQ_ID_NONE;
    end else begin
      irq    <= irq_next;
      irq_id <= id_next;
    end
  end

endmodule

// File: tb/tb_io_irq_ctrl.sv
// Bench for io_irq_ctrl: table of settled-state vectors plus timed sequences,
// with a level-mode and a pulse-mode instance sharing the same stimulus.
module tb_io_irq_ctrl;

  logic       ACLK = 1'b0;
  logic       ARESETn = 1'b0;
  logic [7:0] sw = '0, sw_ena = '0, sw_clr = '0;
  logic [4:0] btn = '0, btn_ena = '0, btn_clr = '0, pos = '0, neg = '0;

  logic [7:0] sw_sts, sw_sts_p;
  logic [4:0] btn_sts, btn_sts_p;
  logic       irq, irq_p;
  logic [3:0] irq_id, irq_id_p;

  always #5 ACLK = ~ACLK;

  io_irq_ctrl #(.N_SW(8), .N_BTN(5), .SYNC_STAGES(2), .IRQ_LEVEL(1'b1)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn), .switch(sw), .button(btn),
    .int_switch_ena(sw_ena), .int_button_ena(btn_ena),
    .int_switch_clr(sw_clr), .int_button_clr(btn_clr),
    .button_posedge(pos), .button_negedge(neg),
    .int_switch_sts(sw_sts), .int_button_sts(btn_sts),
    .irq(irq), .irq_id(irq_id)
  );

  io_irq_ctrl #(.N_SW(8), .N_BTN(5), .SYNC_STAGES(2), .IRQ_LEVEL(1'b0)) dut_p (
    .ACLK(ACLK), .ARESETn(ARESETn), .switch(sw), .button(btn),
    .int_switch_ena(sw_ena), .int_button_ena(btn_ena),
    .int_switch_clr(sw_clr), .int_button_clr(btn_clr),
    .button_posedge(pos), .button_negedge(neg),
    .int_switch_sts(sw_sts_p), .int_button_sts(btn_sts_p),
    .irq(irq_p), .irq_id(irq_id_p)
  );

  typedef struct packed {
    logic [7:0] sw;
    logic [4:0] btn;
    logic       irq;
    logic [3:0] id;
    logic       irq_p;
  } exp_t;

  typedef struct packed {
    logic [7:0] sw_ena;
    logic [4:0] btn_ena, pos, neg;
    logic [7:0] sw;
    logic [4:0] btn;
    logic [7:0] sw_clr;
    logic [4:0] btn_clr;
    logic [7:0] e_sw;
    logic [4:0] e_btn;
    logic       e_irq;
    logic [3:0] e_id;
  } vec_t;

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];
  vec_t vecs[16];

  function automatic exp_t mk(logic [7:0] s, logic [4:0] b, logic i, logic [3:0] id, logic p);
    exp_t e;
    e.sw = s; e.btn = b; e.irq = i; e.id = id; e.irq_p = p;
    return e;
  endfunction

  function automatic vec_t mkv(logic [7:0] se, logic [4:0] be, logic [4:0] ps, logic [4:0] ng,
                               logic [7:0] s, logic [4:0] b, logic [7:0] sc, logic [4:0] bc,
                               logic [7:0] es, logic [4:0] eb, logic ei, logic [3:0] eid);
    vec_t v;
    v.sw_ena = se; v.btn_ena = be; v.pos = ps; v.neg = ng; v.sw = s; v.btn = b;
    v.sw_clr = sc; v.btn_clr = bc; v.e_sw = es; v.e_btn = eb; v.e_irq = ei; v.e_id = eid;
    return v;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge ACLK);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  // Expectation is queued when the stimulus goes in and retired n cycles later.
  task automatic expect_after(input string tag, input int n, input exp_t e);
    exp_t g;
    sb.push_back(e);
    tick(n);
    g = sb.pop_front();
    chk({tag, ".sw_sts"},  32'(sw_sts),   32'(g.sw));
    chk({tag, ".btn_sts"}, 32'(btn_sts),  32'(g.btn));
    chk({tag, ".irq"},     32'(irq),      32'(g.irq));
    chk({tag, ".irq_id"},  32'(irq_id),   32'(g.id));
    chk({tag, ".irq_p"},   32'(irq_p),    32'(g.irq_p));
    chk({tag, ".sts_p"},   32'({btn_sts_p, sw_sts_p}), 32'({g.btn, g.sw}));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //            sw_en  bt_en  pos    neg    sw     btn    swclr  btclr  e_sw   e_btn  irq   id
    vecs[0]  = mkv(8'h01, 5'h00, 5'h04, 5'h00, 8'h00, 5'h00, 8'h00, 5'h00, 8'h00, 5'h00, 1'b0, 4'hF);
    vecs[1]  = mkv(8'h01, 5'h00, 5'h04, 5'h00, 8'h01, 5'h00, 8'h00, 5'h00, 8'h01, 5'h00, 1'b1, 4'h0);
    vecs[2]  = mkv(8'h01, 5'h00, 5'h04, 5'h00, 8'h01, 5'h00, 8'h01, 5'h00, 8'h00, 5'h00, 1'b0, 4'hF);
    vecs[3]  = mkv(8'h01, 5'h1F, 5'h04, 5'h00, 8'h01, 5'h04, 8'h00, 5'h00, 8'h00, 5'h04, 1'b1, 4'hA);
    vecs[4]  = mkv(8'h01, 5'h1F, 5'h04, 5'h00, 8'h01, 5'h00, 8'h00, 5'h00, 8'h00, 5'h04, 1'b1, 4'hA);
    vecs[5]  = mkv(8'h01, 5'h1F, 5'h04, 5'h00, 8'h01, 5'h08, 8'h00, 5'h00, 8'h00, 5'h04, 1'b1, 4'hA);
    vecs[6]  = mkv(8'h01, 5'h1F, 5'h04, 5'h00, 8'h01, 5'h08, 8'h00, 5'h04, 8'h00, 5'h00, 1'b0, 4'hF);
    vecs[7]  = mkv(8'h00, 5'h1F, 5'h04, 5'h00, 8'h00, 5'h08, 8'h00, 5'h00, 8'h00, 5'h00, 1'b0, 4'hF);
    vecs[8]  = mkv(8'h01, 5'h1F, 5'h04, 5'h00, 8'h00, 5'h08, 8'h00, 5'h00, 8'h00, 5'h00, 1'b0, 4'hF);
    vecs[9]  = mkv(8'hFF, 5'h1F, 5'h06, 5'h00, 8'h20, 5'h0A, 8'h00, 5'h00, 8'h20, 5'h02, 1'b1, 4'h5);
    vecs[10] = mkv(8'hDF, 5'h1F, 5'h06, 5'h00, 8'h20, 5'h0A, 8'h00, 5'h00, 8'h20, 5'h02, 1'b1, 4'h9);
    vecs[11] = mkv(8'h00, 5'h00, 5'h06, 5'h00, 8'h20, 5'h0A, 8'h00, 5'h00, 8'h20, 5'h02, 1'b0, 4'hF);
    vecs[12] = mkv(8'hFF, 5'h1F, 5'h06, 5'h00, 8'h20, 5'h0A, 8'h00, 5'h00, 8'h20, 5'h02, 1'b1, 4'h5);
    vecs[13] = mkv(8'hFF, 5'h1F, 5'h06, 5'h00, 8'h20, 5'h0A, 8'h00, 5'h02, 8'h20, 5'h00, 1'b1, 4'h5);
    vecs[14] = mkv(8'hFF, 5'h1F, 5'h06, 5'h02, 8'h20, 5'h08, 8'h00, 5'h00, 8'h20, 5'h02, 1'b1, 4'h5);
    vecs[15] = mkv(8'hFF, 5'h1F, 5'h06, 5'h02, 8'h20, 5'h08, 8'h20, 5'h02, 8'h00, 5'h00, 1'b0, 4'hF);

    pos = 5'h04;
    tick(2);
    expect_after("reset", 0, mk(8'h00, 5'h00, 1'b0, 4'hF, 1'b0));
    ARESETn = 1'b1;
    tick(5);

    // Settled state after each vector: one cycle of clear pulse, then four more.
    for (int i = 0; i < 16; i++) begin
      sw_ena = vecs[i].sw_ena; btn_ena = vecs[i].btn_ena;
      pos = vecs[i].pos; neg = vecs[i].neg;
      sw = vecs[i].sw; btn = vecs[i].btn;
      sw_clr = vecs[i].sw_clr; btn_clr = vecs[i].btn_clr;
      tick(1);
      sw_clr = '0; btn_clr = '0;
      expect_after($sformatf("row%0d", i), 4,
                   mk(vecs[i].e_sw, vecs[i].e_btn, vecs[i].e_irq, vecs[i].e_id, 1'b0));
    end

    // Latency: status after 3 edges, irq/irq_id after 4, clear takes 1 then 2.
    sw = 8'h21;
    expect_after("lat_e2", 2, mk(8'h00, 5'h00, 1'b0, 4'hF, 1'b0));
    expect_after("lat_e3", 1, mk(8'h01, 5'h00, 1'b0, 4'hF, 1'b0));
    expect_after("lat_e4", 1, mk(8'h01, 5'h00, 1'b1, 4'h0, 1'b1));
    expect_after("lat_e5", 1, mk(8'h01, 5'h00, 1'b1, 4'h0, 1'b0));
    sw_clr = 8'h01;
    expect_after("clr_e1", 1, mk(8'h00, 5'h00, 1'b1, 4'h0, 1'b0));
    sw_clr = '0;
    expect_after("clr_e2", 1, mk(8'h00, 5'h00, 1'b0, 4'hF, 1'b0));

    // Clear pulse on the same edge as a new switch-3 event.
    sw = 8'h29;
    expect_after("col_set", 5, mk(8'h08, 5'h00, 1'b1, 4'h3, 1'b0));
    sw = 8'h21;
    expect_after("col_pre", 2, mk(8'h08, 5'h00, 1'b1, 4'h3, 1'b0));
    sw_clr = 8'h08;
    expect_after("col_edge", 1, mk(8'h08, 5'h00, 1'b1, 4'h3, 1'b0));
    sw_clr = '0;
    expect_after("col_after", 1, mk(8'h08, 5'h00, 1'b1, 4'h3, 1'b0));
    sw_clr = 8'h08;
    tick(1);
    sw_clr = '0;
    expect_after("col_clr", 1, mk(8'h00, 5'h00, 1'b0, 4'hF, 1'b0));

    // Events on consecutive cycles give back-to-back pulses.
    sw = 8'h23;
    tick(1);
    sw = 8'h27;
    expect_after("b2b_e3", 2, mk(8'h02, 5'h00, 1'b0, 4'hF, 1'b0));
    expect_after("b2b_e4", 1, mk(8'h06, 5'h00, 1'b1, 4'h1, 1'b1));
    expect_after("b2b_e5", 1, mk(8'h06, 5'h00, 1'b1, 4'h1, 1'b1));
    expect_after("b2b_e6", 1, mk(8'h06, 5'h00, 1'b1, 4'h1, 1'b0));

    // Reset while pending, then lines held high through reset.
    ARESETn = 1'b0;
    expect_after("rst_mid", 1, mk(8'h00, 5'h00, 1'b0, 4'hF, 1'b0));
    sw = 8'hFF; btn = 5'h1F;
    tick(2);
    ARESETn = 1'b1;
    expect_after("rst_held", 8, mk(8'h00, 5'h00, 1'b0, 4'hF, 1'b0));
    sw = 8'hFE;
    expect_after("rst_alive", 4, mk(8'h01, 5'h00, 1'b1, 4'h0, 1'b1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
